video_analyzer: RTL

- Measures the timing of a video stream (pixel-enable, HSync, VSync, DE), for example the mixer output before it reaches the scaler or OSD.
- Reports total and active width and height once they have been identical for several consecutive frames.
- Lets downstream logic (scaler setup, OSD placement, status display) adapt to the mode produced by scandoubler on or off.
- Pure observer: it never modifies or delays the video.

---
 rtl/video_pkg.sv | 20 ++
 rtl/video_line_counter.sv | 62 ++++++
 rtl/video_analyzer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared types for the video timing analyzer: result record, FSM states and
// the default counter width.
package video_pkg;

   localparam int VID_CW = 12;

   typedef struct packed {
      logic [VID_CW-1:0] htotal;
      logic [VID_CW-1:0] hactive;
      logic [VID_CW-1:0] vtotal;
      logic [VID_CW-1:0] vactive;
   } vid_timing_t;

   typedef enum logic [1:0] {
      IDLE,
      TRACK,
      LOCKED
   } va_state_t;

endpackage

// File: rtl/video_line_counter.sv
// Per-line measurement: samples hs on ce_pix, counts samples and DE samples
// per line and strobes line_done on each hs rise.
module video_line_counter #(
   parameter int CW = 12
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          ce_pix,
   input  logic          hs,
   input  logic          de,
   output logic          line_done,
   output logic          line_act,
   output logic [CW-1:0] h_last,
   output logic [CW-1:0] a_last,
   output logic          sat
);

   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic          hs_q;
   logic [CW-1:0] hcnt;
   logic [CW-1:0] decnt;
   logic [CW-1:0] h_last_q;
   logic [CW-1:0] a_last_q;

   assign line_done = ce_pix & hs & ~hs_q;
   assign line_act  = line_done & (decnt != '0);

   // h_last/a_last already reflect a line closing on this very sample, so a
   // frame ending on the same sample sees its final line.
   assign h_last = line_done ? hcnt  : h_last_q;
   assign a_last = line_act  ? decnt : a_last_q;
   assign sat    = (hcnt == CNT_MAX) | (decnt == CNT_MAX);

   // NOTE: sequential state uses non-blocking assignments so every register
   // in the block updates from pre-edge values regardless of statement order.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         hs_q     <= 1'b0;
         hcnt     <= '0;
         decnt    <= '0;
         h_last_q <= '0;
         a_last_q <= '0;
      end else if (ce_pix) begin
         hs_q <= hs;
         if (line_done) begin
            h_last_q <= hcnt;
            hcnt     <= CNT_ONE;
            if (decnt != '0)
               a_last_q <= decnt;
            decnt <= {{(CW-1){1'b0}}, de};
         end else begin
            if (hcnt != CNT_MAX)
               hcnt <= hcnt + 1'b1;
            if (de && (decnt != CNT_MAX))
               decnt <= decnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/video_analyzer.sv
// Video timing observer: measures each frame between vs rises and publishes
// the timing once it has repeated for STABLE_FRAMES frames. CW must equal VID_CW.
module video_analyzer
   import video_pkg::*;
#(
   parameter int CW            = VID_CW,
   parameter int STABLE_FRAMES = 2
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          ce_pix,
   input  logic          hs,
   input  logic          vs,
   input  logic          de,
   output logic [CW-1:0] htotal,
   output logic [CW-1:0] hactive,
   output logic [CW-1:0] vtotal,
   output logic [CW-1:0] vactive,
   output logic          valid,
   output logic          changed
);

   localparam int            SW       = $clog2(STABLE_FRAMES + 1);
   localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_FRAMES);
   localparam logic [SW-1:0] STAB_ONE = SW'(1);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   logic          line_done;
   logic          line_act;
   logic          line_sat;
   logic [CW-1:0] h_last;
   logic [CW-1:0] a_last;

   video_line_counter #(.CW(CW)) u_line (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .ce_pix    (ce_pix),
      .hs        (hs),
      .de        (de),
      .line_done (line_done),
      .line_act  (line_act),
      .h_last    (h_last),
      .a_last    (a_last),
      .sat       (line_sat)
   );

   logic          vs_q;
   logic          armed;
   logic          ovf;
   logic [CW-1:0] lines;
   logic [CW-1:0] lines_act;
   logic [CW-1:0] lines_n;
   logic [CW-1:0] lines_act_n;
   logic          vs_rise;
   logic          cnt_sat;
   logic          frame_bad;
   vid_timing_t   meas;

   // Line counts include an hs rise on the same sample as the vs rise.
   assign lines_n     = (line_done && (lines != CNT_MAX)) ? lines + 1'b1 : lines;
   assign lines_act_n = (line_act && (lines_act != CNT_MAX)) ? lines_act + 1'b1 : lines_act;
   assign vs_rise     = ce_pix & vs & ~vs_q;
   assign cnt_sat     = line_sat | (lines_n == CNT_MAX) | (lines_act_n == CNT_MAX);
   assign frame_bad   = ovf | cnt_sat | (lines_n == '0) | (lines_act_n == '0);
   assign meas        = '{htotal: h_last, hactive: a_last, vtotal: lines_n, vactive: lines_act_n};

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         vs_q      <= 1'b0;
         armed     <= 1'b0;
         ovf       <= 1'b0;
         lines     <= '0;
         lines_act <= '0;
      end else if (ce_pix) begin
         vs_q <= vs;
         if (vs_rise) begin
            armed     <= 1'b1;
            ovf       <= 1'b0;
            lines     <= '0;
            lines_act <= '0;
         end else begin
            lines     <= lines_n;
            lines_act <= lines_act_n;
            ovf       <= ovf | cnt_sat;
         end
      end
   end

   va_state_t     state, state_n;
   logic [SW-1:0] stab, stab_n, stab_inc;
   vid_timing_t   prev, prev_n;
   vid_timing_t   pub, pub_n;
   logic          valid_n;
   logic          changed_n;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         stab    <= '0;
         prev    <= '0;
         pub     <= '0;
         valid   <= 1'b0;
         changed <= 1'b0;
      end else begin
         state   <= state_n;
         stab    <= stab_n;
         prev    <= prev_n;
         pub     <= pub_n;
         valid   <= valid_n;
         changed <= changed_n;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the decision tree can leave a latch behind.
   always_comb begin
      state_n   = state;
      stab_n    = stab;
      prev_n    = prev;
      pub_n     = pub;
      valid_n   = valid;
      changed_n = 1'b0;
      stab_inc  = (stab == STAB_MAX) ? stab : stab + 1'b1;
      if (vs_rise && armed) begin
         if (frame_bad) begin
            stab_n  = '0;
            valid_n = 1'b0;
            state_n = TRACK;
         end else begin
            prev_n = meas;
            stab_n = (meas == prev) ? stab_inc : STAB_ONE;
            if ((stab_n == STAB_MAX) && ((state != LOCKED) || (meas != pub))) begin
               pub_n     = meas;
               changed_n = 1'b1;
               valid_n   = 1'b1;
               state_n   = LOCKED;
            end else if ((state == LOCKED) && (meas != prev)) begin
               valid_n = 1'b0;
               state_n = TRACK;
            end else if (state == IDLE) begin
               state_n = TRACK;
            end
         end
      end
   end

   assign htotal  = pub.htotal;
   assign hactive = pub.hactive;
   assign vtotal  = pub.vtotal;
   assign vactive = pub.vactive;

endmodule
